// File: rtl/pe_matrix_expectation_seq.sv
// Sequencing/accumulation stage for the sigma-point expectation.
// Collects N_SIGMA (weight, sigma) beats. Each beat is folded into a bank of
// DIM_SIGMA 64-bit accumulators through an external combinational MAC array.
// The finished expected vector is then offered downstream with valid/ready.
module pe_matrix_expectation_seq #(
  parameter int DIM_SIGMA = 5,
  parameter int N_SIGMA   = 11,
  parameter int CNT_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             weight,
  input  logic [32*DIM_SIGMA-1:0] sigma,
  output logic [31:0]             mac_weight,
  output logic [32*DIM_SIGMA-1:0] mac_sigma,
  output logic [64*DIM_SIGMA-1:0] mac_run_sum,
  input  logic [64*DIM_SIGMA-1:0] mac_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [64*DIM_SIGMA-1:0] expected,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_acc [DIM_SIGMA];

  logic w_beat;
  logic w_last_beat;
  logic w_clear;

  // A beat is only possible in ACCUM, so in_ready gates the handshake.
  assign w_beat      = in_valid && (r_state == S_ACCUM);
  assign w_last_beat = w_beat && (r_cnt == CNT_W'(N_SIGMA - 1));
  assign w_clear     = (r_state == S_IDLE) && start;

  // The comb stage sees the live inputs. Its running-sum input comes only
  // from registers, which keeps the loop through the MAC array cut.
  assign mac_weight = weight;
  assign mac_sigma  = sigma;

  genvar gi;
  generate
    for (gi = 0; gi < DIM_SIGMA; gi++) begin : g_pack
      assign mac_run_sum[64*gi +: 64] = r_acc[gi];
      assign expected[64*gi +: 64]    = r_acc[gi];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs decoded from the current state.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_ACCUM;
        end
      end
      S_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (w_last_beat) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Beat counter: cleared by start, advanced on every accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_clear) begin
      r_cnt <= '0;
    end else if (w_beat) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Accumulators. They take the MAC result on each beat. They are held
  // through DONE and IDLE, so the last result stays readable until the next
  // start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DIM_SIGMA; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_clear) begin
      for (int i = 0; i < DIM_SIGMA; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_beat) begin
      for (int i = 0; i < DIM_SIGMA; i++) begin
        r_acc[i] <= mac_out[64*i +: 64];
      end
    end
  end

endmodule

// File: tb/tb_pe_matrix_expectation_seq.sv
// Randomized bench for pe_matrix_expectation_seq.
// It stands in for the combinational MAC array. The reference is a plain
// sum of weight*sigma products over the accepted beats.
module tb_pe_matrix_expectation_seq;

  localparam int DIM = 5;
  localparam int N   = 11;
  localparam int CW  = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        weight;
  logic [32*DIM-1:0]  sigma;
  logic [31:0]        mac_weight;
  logic [32*DIM-1:0]  mac_sigma;
  logic [64*DIM-1:0]  mac_run_sum;
  logic [64*DIM-1:0]  mac_out;
  logic               out_valid;
  logic               out_ready;
  logic [64*DIM-1:0]  expected;
  logic               busy;

  always #5 clk = ~clk;

  pe_matrix_expectation_seq #(.DIM_SIGMA(DIM), .N_SIGMA(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .weight(weight), .sigma(sigma), .mac_weight(mac_weight), .mac_sigma(mac_sigma),
    .mac_run_sum(mac_run_sum), .mac_out(mac_out), .out_valid(out_valid),
    .out_ready(out_ready), .expected(expected), .busy(busy)
  );

  // Stand-in for the external zero-latency MAC array.
  always_comb begin
    mac_out = '0;
    for (int e = 0; e < DIM; e++) begin
      mac_out[64*e +: 64] = mac_run_sum[64*e +: 64] +
        64'(longint'($signed(mac_weight)) * longint'($signed(mac_sigma[32*e +: 32])));
    end
  end

  int     n_vec = 0;
  int     n_bad = 0;
  longint ref_sum [DIM];
  int     w_tab [N];
  int     s_tab [N][DIM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check_vec(input string tag, input logic [64*DIM-1:0] v);
    for (int e = 0; e < DIM; e++) begin
      chk($sformatf("%s[%0d]", tag, e), v[64*e +: 64], 64'(ref_sum[e]));
    end
  endtask

  // 0: w=1, s=i+1   1: w=-1, s=0x7FFFFFFF   2: large positive (wraps)   3: random
  task automatic set_pattern(input int pat);
    for (int b = 0; b < N; b++) begin
      case (pat)
        0:       w_tab[b] = 1;
        1:       w_tab[b] = -1;
        2:       w_tab[b] = 32'h7FFF_FFFF;
        default: w_tab[b] = int'($urandom);
      endcase
      for (int e = 0; e < DIM; e++) begin
        case (pat)
          0:       s_tab[b][e] = e + 1;
          1, 2:    s_tab[b][e] = 32'h7FFF_FFFF;
          default: s_tab[b][e] = int'($urandom);
        endcase
      end
    end
  endtask

  task automatic drive_beat(input int b);
    weight = w_tab[b];
    for (int e = 0; e < DIM; e++) sigma[32*e +: 32] = s_tab[b][e];
  endtask

  // One full expectation. vmode: 0 valid held, 1 toggled, 2 random.
  // Holds DONE for hold cycles with start pulses, then releases it.
  task automatic run(input int vmode, input int hold, output int edges);
    int beats;
    int guard;
    bit v;
    for (int e = 0; e < DIM; e++) ref_sum[e] = 0;
    @(posedge clk); #1 start = 1'b1; in_valid = 1'b0;
    @(posedge clk); edges = 1; #1 start = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < N && guard < 400) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (guard % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      drive_beat(beats);
      @(negedge clk);
      chk("in_ready_accum", in_ready, 1);
      chk("out_valid_early", out_valid, 0);
      chk("busy_accum", busy, 1);
      chk("mac_weight", mac_weight, weight);
      check_vec("run_sum", mac_run_sum);
      @(posedge clk); edges++; #1;
      if (v) begin
        for (int e = 0; e < DIM; e++)
          ref_sum[e] += longint'(w_tab[beats]) * longint'(s_tab[beats][e]);
        beats++;
      end
      guard++;
    end
    if (guard >= 400) chk("beat_budget", 64'(guard), 64'(0));
    // Inputs left active in DONE must not disturb the frozen result.
    in_valid = 1'b1;
    weight = $urandom;
    @(negedge clk);
    chk("out_valid_done", out_valid, 1);
    chk("in_ready_done", in_ready, 0);
    chk("busy_done", busy, 1);
    check_vec("expected", expected);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1 start = 1'(k % 2 == 0);
      @(negedge clk);
      chk("out_valid_hold", out_valid, 1);
      check_vec("expected_hold", expected);
    end
    // Start coinciding with the DONE->IDLE transition is ignored.
    @(posedge clk); #1 start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("out_valid_idle", out_valid, 0);
    chk("busy_idle", busy, 0);
    chk("in_ready_idle", in_ready, 0);
    check_vec("expected_held", expected);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_no_restart", busy, 0);
  endtask

  // Abort with an asynchronous reset after nb beats.
  task automatic abort_run(input int nb);
    set_pattern(3);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; in_valid = 1'b1;
    for (int b = 0; b < nb; b++) begin
      drive_beat(b);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("out_valid_pre_rst", out_valid, (nb == N) ? 1 : 0);
    #2 rst = 1'b1;
    #1;
    chk("out_valid_async_rst", out_valid, 0);
    chk("in_ready_async_rst", in_ready, 0);
    chk("busy_async_rst", busy, 0);
    for (int e = 0; e < DIM; e++) ref_sum[e] = 0;
    check_vec("acc_async_rst", mac_run_sum);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 0);
  endtask

  int edges;

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    weight = '0; sigma = '0;
    for (int e = 0; e < DIM; e++) ref_sum[e] = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    check_vec("rst_expected", expected);
    check_vec("rst_run_sum", mac_run_sum);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    // Idle with in_valid but no start: nothing is accepted.
    in_valid = 1'b1; weight = 32'd3; sigma = '1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("idle_in_ready", in_ready, 0);
      chk("idle_busy", busy, 0);
      check_vec("idle_acc", expected);
    end
    in_valid = 1'b0;

    // Basic sum with minimum latency, then the closed-form values.
    set_pattern(0);
    run(0, 2, edges);
    chk("latency_edges", 64'(edges), 64'(N + 1));
    for (int e = 0; e < DIM; e++)
      chk($sformatf("closed_form[%0d]", e), expected[64*e +: 64], 64'(N * (e + 1)));

    // Same data, valid toggled every cycle.
    run(1, 0, edges);
    chk("latency_toggle", 64'(edges), 64'(2 * N));

    // Backpressure on random data.
    set_pattern(3);
    run(0, 5, edges);

    // Signed products and 64-bit wrap-around.
    set_pattern(1);
    run(2, 1, edges);
    for (int e = 0; e < DIM; e++)
      chk($sformatf("neg_sum[%0d]", e), expected[64*e +: 64], 64'(-11 * 64'sh7FFF_FFFF));
    set_pattern(2);
    run(0, 0, edges);

    // Reset mid-ACCUM and in DONE, each followed by a clean run.
    abort_run(6);
    set_pattern(0);
    run(0, 0, edges);
    abort_run(N);
    set_pattern(3);
    run(2, 3, edges);

    // Random soak.
    for (int r = 0; r < 4; r++) begin
      set_pattern(3);
      run(2, int'($urandom_range(0, 3)), edges);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, want completion");
    $fatal(1, "timeout");
  end

endmodule
